// File: rtl/airlock_sequencer_pkg.sv
// Shared definitions for the airlock sequencer: state encodings, default cycle counts, output decode.
// Build option: define AIRLOCK_AUTOCLOSE_EN to close an open door automatically after AUTO_CLOSE_CYCLES.
package airlock_sequencer_pkg;

  localparam logic [2:0] P_IDLE       = 3'd0;
  localparam logic [2:0] INNER_OPEN   = 3'd1;
  localparam logic [2:0] EVACUATING   = 3'd2;
  localparam logic [2:0] V_IDLE       = 3'd3;
  localparam logic [2:0] OUTER_OPEN   = 3'd4;
  localparam logic [2:0] PRESSURIZING = 3'd5;

  localparam int DEF_EVAC_CYCLES       = 4;
  localparam int DEF_PRESS_CYCLES      = 6;
  localparam int DEF_AUTO_CLOSE_CYCLES = 8;

  typedef struct packed {
    logic inner_open;
    logic outer_open;
    logic evacuate;
    logic pressurize;
    logic ev_state;
    logic busy;
  } airlock_outs_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) begin
      m = b;
    end else begin
      m = m;
    end
    if (c > m) begin
      m = c;
    end else begin
      m = m;
    end
    return m;
  endfunction

  // Every output is a pure function of the state it belongs to.
  function automatic airlock_outs_t decode_outs(input logic [2:0] st);
    airlock_outs_t o;
    o = '{default: 1'b0};
    case (st)
      INNER_OPEN:   o.inner_open = 1'b1;
      EVACUATING:   begin
        o.evacuate = 1'b1;
        o.busy     = 1'b1;
      end
      V_IDLE:       o.ev_state = 1'b1;
      OUTER_OPEN:   begin
        o.outer_open = 1'b1;
        o.ev_state   = 1'b1;
      end
      PRESSURIZING: begin
        o.pressurize = 1'b1;
        o.ev_state   = 1'b1;
        o.busy       = 1'b1;
      end
      default:      o = '{default: 1'b0};
    endcase
    return o;
  endfunction

endpackage

// File: rtl/airlock_timer.sv
// Loadable down-counter used for pump durations and the door auto-close timeout.
// Holds at zero; never wraps.
module airlock_timer #(
  parameter int W = 4
) (
  input  logic         Clock,
  input  logic         Reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] count_r;

  // Count register: load wins over decrement, decrement stops at zero.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      count_r <= {W{1'b0}};
    end else if (load) begin
      count_r <= load_val;
    end else if (count_r != {W{1'b0}}) begin
      count_r <= count_r - {{(W-1){1'b0}}, 1'b1};
    end else begin
      count_r <= count_r;
    end
  end

  assign zero = (count_r == {W{1'b0}});

endmodule

// File: rtl/airlock_sequencer.sv
// Two-door airlock sequencer: door requests, pump timing and door interlocks.
// Build option: AIRLOCK_AUTOCLOSE_EN enables the open-door timeout.
module airlock_sequencer
  import airlock_sequencer_pkg::*;
#(
  parameter int EVAC_CYCLES       = DEF_EVAC_CYCLES,
  parameter int PRESS_CYCLES      = DEF_PRESS_CYCLES,
  parameter int AUTO_CLOSE_CYCLES = DEF_AUTO_CLOSE_CYCLES
) (
  input  logic Clock,
  input  logic Reset,
  input  logic ReqInner,
  input  logic ReqOuter,
  input  logic CloseReq,
  output logic InnerOpen,
  output logic OuterOpen,
  output logic Evacuate,
  output logic Pressurize,
  output logic EVState,
  output logic Busy
);

  localparam int TW = $clog2(max3(EVAC_CYCLES, PRESS_CYCLES, AUTO_CLOSE_CYCLES) + 1);

  localparam logic [TW-1:0] EVAC_LOAD  = TW'(EVAC_CYCLES - 1);
  localparam logic [TW-1:0] PRESS_LOAD = TW'(PRESS_CYCLES - 1);
`ifdef AIRLOCK_AUTOCLOSE_EN
  localparam logic [TW-1:0] OPEN_LOAD  = TW'(AUTO_CLOSE_CYCLES - 1);
`else
  localparam logic [TW-1:0] OPEN_LOAD  = {TW{1'b0}};
`endif

  logic [2:0]    state_r;
  logic [2:0]    next_s;
  logic          load_s;
  logic [TW-1:0] load_val_s;
  logic          timer_zero_s;
  airlock_outs_t outs_r;

  // Next-state selection; idle states favour the door that needs no pump.
  always_comb begin
    next_s = state_r;
    case (state_r)
      P_IDLE: begin
        if (ReqInner) begin
          next_s = INNER_OPEN;
        end else if (ReqOuter) begin
          next_s = EVACUATING;
        end else begin
          next_s = P_IDLE;
        end
      end
      EVACUATING: begin
        if (timer_zero_s) begin
          next_s = OUTER_OPEN;
        end else begin
          next_s = EVACUATING;
        end
      end
      V_IDLE: begin
        if (ReqOuter) begin
          next_s = OUTER_OPEN;
        end else if (ReqInner) begin
          next_s = PRESSURIZING;
        end else begin
          next_s = V_IDLE;
        end
      end
      PRESSURIZING: begin
        if (timer_zero_s) begin
          next_s = INNER_OPEN;
        end else begin
          next_s = PRESSURIZING;
        end
      end
      INNER_OPEN: begin
        if (CloseReq) begin
          next_s = P_IDLE;
`ifdef AIRLOCK_AUTOCLOSE_EN
        end else if (timer_zero_s) begin
          next_s = P_IDLE;
`endif
        end else begin
          next_s = INNER_OPEN;
        end
      end
      OUTER_OPEN: begin
        if (CloseReq) begin
          next_s = V_IDLE;
`ifdef AIRLOCK_AUTOCLOSE_EN
        end else if (timer_zero_s) begin
          next_s = V_IDLE;
`endif
        end else begin
          next_s = OUTER_OPEN;
        end
      end
      default: next_s = P_IDLE;
    endcase
  end

  // Reload the timer on every state change; idle states load zero so an early close clears it.
  always_comb begin
    load_s     = (next_s != state_r);
    load_val_s = {TW{1'b0}};
    case (next_s)
      EVACUATING:   load_val_s = EVAC_LOAD;
      PRESSURIZING: load_val_s = PRESS_LOAD;
      INNER_OPEN:   load_val_s = OPEN_LOAD;
      OUTER_OPEN:   load_val_s = OPEN_LOAD;
      default:      load_val_s = {TW{1'b0}};
    endcase
  end

  airlock_timer #(
    .W (TW)
  ) u_timer (
    .Clock    (Clock),
    .Reset    (Reset),
    .load     (load_s),
    .load_val (load_val_s),
    .zero     (timer_zero_s)
  );

  // State and outputs register together so outputs always match the state just entered.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_r <= P_IDLE;
      outs_r  <= '{default: 1'b0};
    end else begin
      state_r <= next_s;
      outs_r  <= decode_outs(next_s);
    end
  end

  assign InnerOpen  = outs_r.inner_open;
  assign OuterOpen  = outs_r.outer_open;
  assign Evacuate   = outs_r.evacuate;
  assign Pressurize = outs_r.pressurize;
  assign EVState    = outs_r.ev_state;
  assign Busy       = outs_r.busy;

endmodule

// File: tb/tb_airlock_sequencer.sv
// Self-checking bench for airlock_sequencer: cycle model feeds an expected-output queue.
// Honours AIRLOCK_AUTOCLOSE_EN the same way as the design.
module tb_airlock_sequencer;

  localparam int E  = 4;
  localparam int P  = 6;
  localparam int AC = 8;
`ifdef AIRLOCK_AUTOCLOSE_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  localparam int S_PI = 0, S_IO = 1, S_EV = 2, S_VI = 3, S_OO = 4, S_PR = 5;

  logic Clock, Reset, ReqInner, ReqOuter, CloseReq;
  logic InnerOpen, OuterOpen, Evacuate, Pressurize, EVState, Busy;

  int n_checks = 0;
  int n_pass   = 0;
  int ms = S_PI;
  int mc = 0;
  logic [5:0] exp_q[$];

  airlock_sequencer #(
    .EVAC_CYCLES       (E),
    .PRESS_CYCLES      (P),
    .AUTO_CLOSE_CYCLES (AC)
  ) dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .ReqInner   (ReqInner),
    .ReqOuter   (ReqOuter),
    .CloseReq   (CloseReq),
    .InnerOpen  (InnerOpen),
    .OuterOpen  (OuterOpen),
    .Evacuate   (Evacuate),
    .Pressurize (Pressurize),
    .EVState    (EVState),
    .Busy       (Busy)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [5:0] model_outs(input int s);
    logic io, oo, ev, pr, evs;
    io  = (s == S_IO);
    oo  = (s == S_OO);
    ev  = (s == S_EV);
    pr  = (s == S_PR);
    evs = (s == S_VI) || (s == S_OO) || (s == S_PR);
    return {io, oo, ev, pr, evs, ev | pr};
  endfunction

  // Advance the reference model by one rising edge using the inputs the DUT sees.
  task automatic model_edge(input logic rst, input logic ri, input logic ro, input logic cr);
    if (rst) begin
      ms = S_PI;
      mc = 0;
    end else begin
      case (ms)
        S_PI: if (ri) begin ms = S_IO; mc = AC; end
              else if (ro) begin ms = S_EV; mc = E; end
        S_EV: if (mc <= 1) begin ms = S_OO; mc = AC; end else mc--;
        S_VI: if (ro) begin ms = S_OO; mc = AC; end
              else if (ri) begin ms = S_PR; mc = P; end
        S_PR: if (mc <= 1) begin ms = S_IO; mc = AC; end else mc--;
        S_IO: if (cr || (AUTO && mc <= 1)) ms = S_PI; else mc--;
        S_OO: if (cr || (AUTO && mc <= 1)) ms = S_VI; else mc--;
        default: ms = S_PI;
      endcase
    end
  endtask

  // One clock: drive on the falling edge, predict at the rising edge, compare just after it.
  task automatic cyc(input logic ri, input logic ro, input logic cr, input logic rst = 1'b0);
    logic [5:0] exp_v;
    logic [5:0] obs_v;
    @(negedge Clock);
    Reset    = rst;
    ReqInner = ri;
    ReqOuter = ro;
    CloseReq = cr;
    @(posedge Clock);
    model_edge(rst, ri, ro, cr);
    exp_q.push_back(model_outs(ms));
    #1;
    exp_v = exp_q.pop_front();
    obs_v = {InnerOpen, OuterOpen, Evacuate, Pressurize, EVState, Busy};
    check("outs", {26'd0, obs_v}, {26'd0, exp_v});
    check("interlock",
          {31'd0, (InnerOpen & OuterOpen) | (OuterOpen & ~EVState) |
                  (InnerOpen & EVState) | (Evacuate & Pressurize)},
          32'd0);
  endtask

  initial begin
    int cnt;
    Reset = 1'b1; ReqInner = 1'b0; ReqOuter = 1'b0; CloseReq = 1'b0;

    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 1);
    check("reset_outs", {26'd0, InnerOpen, OuterOpen, Evacuate, Pressurize, EVState, Busy}, 32'd0);
    for (int i = 0; i < 10; i++) cyc(0, 0, 0);

    // Reset in the middle of evacuation.
    cyc(0, 1, 0);
    cyc(0, 0, 0);
    cyc(0, 0, 0, 1);
    check("rst_mid_evac_evac", {31'd0, Evacuate}, 32'd0);
    check("rst_mid_evac_evs", {31'd0, EVState}, 32'd0);

    // Evacuate length and door-open edge.
    cyc(0, 1, 0);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (!Evacuate) break;
      cnt++;
      cyc(0, 0, 0);
    end
    check("evac_len", cnt, E);
    check("outer_open_after_evac", {30'd0, OuterOpen, EVState}, 32'd3);
    cyc(0, 0, 1);
    check("outer_closed_evs", {30'd0, OuterOpen, EVState}, 32'd1);

    // Pressurize length with ignored ReqOuter pulses.
    cyc(1, 0, 0);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (!Pressurize) break;
      cnt++;
      cyc(0, i[0], 0);
    end
    check("press_len", cnt, P);
    check("inner_open_after_press", {30'd0, InnerOpen, EVState}, 32'd2);
    cyc(0, 0, 1);

    // Simultaneous requests in each idle state.
    cyc(1, 1, 0);
    check("both_in_pidle", {29'd0, InnerOpen, Evacuate, Pressurize}, 32'd4);
    cyc(0, 0, 1);
    cyc(0, 1, 0);
    for (int i = 0; i < E; i++) cyc(0, 0, 0);
    cyc(0, 0, 1);
    cyc(1, 1, 0);
    check("both_in_vidle", {29'd0, OuterOpen, Evacuate, Pressurize}, 32'd4);

    // Close wins over the opposite request; a held request starts the pump next cycle.
    cyc(1, 0, 1);
    check("close_wins", {30'd0, OuterOpen, Pressurize}, 32'd0);
    cyc(1, 0, 0);
    check("held_req_pumps", {31'd0, Pressurize}, 32'd1);
    for (int i = 0; i < P; i++) cyc(0, 0, 0);

    // Open-door timeout behaviour (door is inner-open here).
    cnt = 0;
    for (int i = 0; i < 50; i++) begin
      if (!InnerOpen) break;
      cnt++;
      cyc(0, 0, 0);
    end
    check("inner_open_len", cnt, AUTO ? AC : 50);
    cyc(0, 0, 1);

    // Random stimulus with occasional reset.
    for (int i = 0; i < 1000; i++) begin
      cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 99) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
